// File: rtl/spike_event_encoder_if.sv
// Event stream bundle between the spike encoder (master) and its consumer (slave).
interface spike_event_encoder_if #(
   parameter int ADDR_W   = 1,
   parameter int TS_WIDTH = 16
) ();
   logic                event_valid;
   logic                event_ready;
   logic [ADDR_W-1:0]   event_addr;
   logic [TS_WIDTH-1:0] event_time;

   modport master (
      output event_valid,
      output event_addr,
      output event_time,
      input  event_ready
   );

   modport slave (
      input  event_valid,
      input  event_addr,
      input  event_time,
      output event_ready
   );
endinterface

// File: rtl/spike_event_encoder.sv
// Spike event encoder: captures per-column spike pulses with a timestamp,
// serialises them lowest-column-first into a first-word-fall-through FIFO
// and counts spikes lost to collisions with a still-pending capture.
module spike_event_encoder #(
   parameter int NUM_COLS   = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int TS_WIDTH   = 16,
   localparam int ADDR_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   output_spike [NUM_COLS],
   input  logic                   enable,
   spike_event_encoder_if.master  ev,
   output logic [7:0]             drop_count,
   output logic                   fifo_full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // timestamp, capture and drop state
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [NUM_COLS-1:0] pending_q, pending_d;
   logic [TS_WIDTH-1:0] stamp_q [NUM_COLS];
   logic [TS_WIDTH-1:0] stamp_d [NUM_COLS];
   logic [7:0]          drop_q, drop_d;

   // FIFO state
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
   logic [TS_WIDTH-1:0] fifo_time_q [FIFO_DEPTH];

   // combinational helpers
   logic                found_s;
   logic [ADDR_W-1:0]   sel_s;
   logic [TS_WIDTH-1:0] sel_stamp_s;
   logic                full_s;
   logic                empty_s;
   logic                push_s;
   logic                pop_s;
   logic [NUM_COLS-1:0] hit_s;
   logic [NUM_COLS-1:0] cap_s;
   logic [8:0]          collide_s;
   logic [9:0]          drop_sum_s;

   // Lowest-index pending column and its stamp: the next event to enqueue.
   always_comb begin
      found_s     = 1'b0;
      sel_s       = '0;
      sel_stamp_s = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (pending_q[i] && !found_s) begin
            found_s     = 1'b1;
            sel_s       = ADDR_W'(i);
            sel_stamp_s = stamp_q[i];
         end else begin
            found_s     = found_s;
         end
      end
   end

   // FIFO status and handshake decode; push is refused while full even if a pop coincides.
   always_comb begin
      full_s  = (count_q == CNT_W'(FIFO_DEPTH));
      empty_s = (count_q == {CNT_W{1'b0}});
      push_s  = found_s && !full_s;
      pop_s   = !empty_s && ev.event_ready;
   end

   // Per-column capture: a column being pushed this edge may recapture; otherwise a spike on a pending column is a drop.
   always_comb begin
      pending_d = pending_q;
      stamp_d   = stamp_q;
      collide_s = 9'd0;
      for (int j = 0; j < NUM_COLS; j++) begin
         hit_s[j]     = push_s && (sel_s == ADDR_W'(j));
         cap_s[j]     = enable && output_spike[j];
         pending_d[j] = (pending_q[j] && !hit_s[j]) || cap_s[j];
         stamp_d[j]   = (cap_s[j] && (!pending_q[j] || hit_s[j])) ? ts_q : stamp_q[j];
         collide_s    = collide_s + {8'd0, (cap_s[j] && pending_q[j] && !hit_s[j])};
      end
   end

   // Timestamp increment and saturating drop accumulation.
   always_comb begin
      ts_d       = ts_q + TS_WIDTH'(1);
      drop_sum_s = {2'b00, drop_q} + {1'b0, collide_s};
      drop_d     = (drop_sum_s > 10'd255) ? 8'hFF : drop_sum_s[7:0];
   end

   // FIFO pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_q      <= '0;
         pending_q <= '0;
         drop_q    <= 8'd0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         for (int k = 0; k < NUM_COLS; k++) begin
            stamp_q[k] <= '0;
         end
      end else begin
         ts_q      <= ts_d;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         stamp_q   <= stamp_d;
      end
   end

   // FIFO storage; contents need no reset because outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_addr_q[wr_ptr_q] <= sel_s;
         fifo_time_q[wr_ptr_q] <= sel_stamp_s;
      end
   end

   assign ev.event_valid = !empty_s;
   assign ev.event_addr  = empty_s ? {ADDR_W{1'b0}}   : fifo_addr_q[rd_ptr_q];
   assign ev.event_time  = empty_s ? {TS_WIDTH{1'b0}} : fifo_time_q[rd_ptr_q];
   assign drop_count     = drop_q;
   assign fifo_full      = full_s;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench for spike_event_encoder (4 columns, 2-deep FIFO, 4-bit timestamps).
module tb_spike_event_encoder;
   localparam int NC = 4;
   localparam int FD = 2;
   localparam int TW = 4;
   localparam int AW = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       spk [NC];
   logic [7:0] drop_count;
   logic       fifo_full;

   spike_event_encoder_if #(.ADDR_W(AW), .TS_WIDTH(TW)) ev_if ();

   spike_event_encoder #(.NUM_COLS(NC), .FIFO_DEPTH(FD), .TS_WIDTH(TW)) dut (
      .clk          (clk),
      .reset        (reset),
      .output_spike (spk),
      .enable       (enable),
      .ev           (ev_if),
      .drop_count   (drop_count),
      .fifo_full    (fifo_full)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [TW-1:0] ts;
   } ev_t;

   typedef struct {
      logic [3:0] spikes;
      logic       en;
      int         exp_ev;
   } vec_t;

   ev_t  exp_q[$];
   ev_t  mon_exp;
   vec_t vecs[6];
   int   checks   = 0;
   int   errors   = 0;
   int   rx_count = 0;
   int   tb_ts    = 0;
   int   rx_before;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tb_ts = (tb_ts + 1) % 16;
   endtask

   task automatic set_spk(input logic [3:0] p);
      for (int c = 0; c < NC; c++) spk[c] = p[c];
   endtask

   // queue expected events for a capture at the current timestamp, lowest column first
   task automatic expect_spk(input logic [3:0] p);
      ev_t e;
      for (int c = 0; c < NC; c++) begin
         if (p[c]) begin
            e.addr = AW'(c);
            e.ts   = TW'(tb_ts);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_ts(input int t);
      for (int n = 0; n < 17 && tb_ts != t; n++) tick();
   endtask

   // scoreboard: every accepted event is compared with the queue head
   always @(negedge clk) begin
      if (reset && ev_if.event_valid && ev_if.event_ready) begin
         rx_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got addr=%0d time=%0d, required no event",
                     ev_if.event_addr, ev_if.event_time);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("event_addr", 32'(ev_if.event_addr), 32'(mon_exp.addr));
            chk("event_time", 32'(ev_if.event_time), 32'(mon_exp.ts));
         end
      end
   end

   initial begin
      vecs[0] = '{spikes: 4'b0001, en: 1'b1, exp_ev: 1};
      vecs[1] = '{spikes: 4'b1000, en: 1'b1, exp_ev: 1};
      vecs[2] = '{spikes: 4'b0110, en: 1'b1, exp_ev: 2};
      vecs[3] = '{spikes: 4'b1111, en: 1'b1, exp_ev: 4};
      vecs[4] = '{spikes: 4'b0101, en: 1'b0, exp_ev: 0};
      vecs[5] = '{spikes: 4'b1010, en: 1'b1, exp_ev: 2};

      reset = 1'b0;
      enable = 1'b1;
      ev_if.event_ready = 1'b0;
      set_spk(4'b0000);
      #2;
      chk("rst_valid", 32'(ev_if.event_valid), 32'd0);
      chk("rst_full",  32'(fifo_full), 32'd0);
      chk("rst_drop",  32'(drop_count), 32'd0);
      chk("rst_addr",  32'(ev_if.event_addr), 32'd0);
      chk("rst_time",  32'(ev_if.event_time), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      tb_ts = 0;

      // table-driven single-edge patterns, drained with ready held high
      ev_if.event_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         set_spk(vecs[v].spikes);
         enable = vecs[v].en;
         if (vecs[v].en) expect_spk(vecs[v].spikes);
         rx_before = rx_count;
         tick();
         set_spk(4'b0000);
         enable = 1'b1;
         repeat (7) tick();
         chk("vec_events", 32'(rx_count - rx_before), 32'(vecs[v].exp_ev));
      end
      chk("vec_drop", 32'(drop_count), 32'd0);

      // single spike: minimum latency then pop
      wait_ts(5);
      set_spk(4'b0100);
      expect_spk(4'b0100);
      tick();
      set_spk(4'b0000);
      chk("lat_valid_n", 32'(ev_if.event_valid), 32'd0);
      tick();
      chk("lat_valid_n1", 32'(ev_if.event_valid), 32'd1);
      chk("lat_addr", 32'(ev_if.event_addr), 32'd2);
      chk("lat_time", 32'(ev_if.event_time), 32'd5);
      tick();
      chk("lat_popped", 32'(ev_if.event_valid), 32'd0);

      // three columns on one edge leave on consecutive edges
      wait_ts(10);
      set_spk(4'b1011);
      expect_spk(4'b1011);
      tick();
      set_spk(4'b0000);
      tick();
      chk("multi_head0", 32'(ev_if.event_addr), 32'd0);
      tick();
      chk("multi_head1", 32'(ev_if.event_addr), 32'd1);
      tick();
      chk("multi_head3", 32'(ev_if.event_addr), 32'd3);
      tick();
      chk("multi_empty", 32'(ev_if.event_valid), 32'd0);
      chk("multi_drop", 32'(drop_count), 32'd0);

      // FIFO fills, columns 2 and 3 held pending, then drained in order
      ev_if.event_ready = 1'b0;
      set_spk(4'b1111);
      expect_spk(4'b1111);
      tick();
      set_spk(4'b0000);
      tick();
      chk("fill_not_full", 32'(fifo_full), 32'd0);
      tick();
      chk("fill_full", 32'(fifo_full), 32'd1);
      tick();
      chk("fill_still_full", 32'(fifo_full), 32'd1);
      ev_if.event_ready = 1'b1;
      repeat (8) tick();
      chk("fill_drained", 32'(ev_if.event_valid), 32'd0);
      chk("fill_drop", 32'(drop_count), 32'd0);
      chk("fill_queue", 32'(exp_q.size()), 32'd0);

      // collision on a held column keeps the first stamp and counts one drop
      ev_if.event_ready = 1'b0;
      set_spk(4'b0011);
      expect_spk(4'b0011);
      tick();
      set_spk(4'b0000);
      tick();
      tick();
      chk("coll_full", 32'(fifo_full), 32'd1);
      set_spk(4'b1000);
      expect_spk(4'b1000);
      tick();
      tick();
      set_spk(4'b0000);
      chk("coll_drop", 32'(drop_count), 32'd1);
      ev_if.event_ready = 1'b1;
      repeat (6) tick();
      chk("coll_queue", 32'(exp_q.size()), 32'd0);

      // timestamp wrap, with same-edge push and recapture of column 1
      wait_ts(15);
      set_spk(4'b0010);
      expect_spk(4'b0010);
      tick();
      expect_spk(4'b0010);
      tick();
      set_spk(4'b0000);
      repeat (4) tick();
      chk("wrap_queue", 32'(exp_q.size()), 32'd0);
      chk("wrap_drop", 32'(drop_count), 32'd1);

      // reset mid-cycle with events queued and pending
      ev_if.event_ready = 1'b0;
      set_spk(4'b0111);
      tick();
      set_spk(4'b0000);
      repeat (3) tick();
      chk("pre_rst_valid", 32'(ev_if.event_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(ev_if.event_valid), 32'd0);
      chk("mid_rst_full",  32'(fifo_full), 32'd0);
      chk("mid_rst_drop",  32'(drop_count), 32'd0);
      chk("mid_rst_addr",  32'(ev_if.event_addr), 32'd0);
      chk("mid_rst_time",  32'(ev_if.event_time), 32'd0);
      tick();
      reset = 1'b1;
      tb_ts = 0;
      ev_if.event_ready = 1'b1;
      set_spk(4'b0001);
      expect_spk(4'b0001);
      tick();
      set_spk(4'b0000);
      chk("post_rst_lat", 32'(ev_if.event_valid), 32'd0);
      tick();
      chk("post_rst_valid", 32'(ev_if.event_valid), 32'd1);
      chk("post_rst_time", 32'(ev_if.event_time), 32'd0);
      repeat (4) tick();
      chk("post_rst_no_stale", 32'(ev_if.event_valid), 32'd0);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
